// File: rtl/char_datapath_if.sv
// Command/status bundle between the game control FSM (master) and the
// character datapath (slave), including the VGA pixel stream.
interface char_datapath_if #(
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int ADDR_W = 11
);
    // Handshake: control raises exactly one command strobe (priority-resolved
    // by the datapath if several are high) and holds it until the matching
    // *_done pulse; the datapath samples commands only while idle in READY.
    logic              init;
    logic              idle;
    logic              attack;
    logic              up;
    logic              down;
    logic              left;
    logic              right;
    logic              draw;
    logic              blocked;
    logic [X_W-1:0]    x_position;
    logic [Y_W-1:0]    y_position;
    logic [ADDR_W-1:0] sprite_addr;
    logic              vga_write;
    logic [X_W-1:0]    char_x;
    logic [Y_W-1:0]    char_y;
    logic [1:0]        facing;
    logic              attacking;
    logic              init_done;
    logic              idle_done;
    logic              attack_done;
    logic              move_done;
    logic              draw_done;

    modport master (
        output init, idle, attack, up, down, left, right, draw, blocked,
        input  x_position, y_position, sprite_addr, vga_write, char_x, char_y,
               facing, attacking, init_done, idle_done, attack_done,
               move_done, draw_done
    );

    modport slave (
        input  init, idle, attack, up, down, left, right, draw, blocked,
        output x_position, y_position, sprite_addr, vga_write, char_x, char_y,
               facing, attacking, init_done, idle_done, attack_done,
               move_done, draw_done
    );
endinterface

// File: rtl/char_datapath.sv
// Character datapath: position/facing/attack state, one-hot command
// execution with done pulses, and a sprite-rectangle pixel scanner for VGA.
module char_datapath #(
    parameter int X_W           = 9,
    parameter int Y_W           = 8,
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 240,
    parameter int SPRITE_W      = 16,
    parameter int SPRITE_H      = 16,
    parameter int STEP          = 1,
    parameter int INIT_X        = 152,
    parameter int INIT_Y        = 112,
    parameter int ATTACK_CYCLES = 8,
    parameter int ADDR_W        = 11
) (
    input  logic       clock,
    input  logic       reset,
    char_datapath_if.slave bus,
    output logic [2:0] state_dbg
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int AW = $clog2(ATTACK_CYCLES + 1);

    localparam logic [X_W:0]    X_MAX   = (X_W + 1)'(SCREEN_W - SPRITE_W);
    localparam logic [Y_W:0]    Y_MAX   = (Y_W + 1)'(SCREEN_H - SPRITE_H);
    localparam logic [X_W:0]    STEP_X  = (X_W + 1)'(STEP);
    localparam logic [Y_W:0]    STEP_Y  = (Y_W + 1)'(STEP);
    localparam logic [X_W-1:0]  X_INIT  = X_W'(INIT_X);
    localparam logic [Y_W-1:0]  Y_INIT  = Y_W'(INIT_Y);
    localparam logic [AW-1:0]   ATK_LAST = AW'(ATTACK_CYCLES - 1);
    localparam logic [AW-1:0]   ATK_PEN  = AW'(ATTACK_CYCLES - 2);

    typedef enum logic [2:0] {
        S_READY    = 3'd0,
        S_INIT     = 3'd1,
        S_IDLE     = 3'd2,
        S_MOVE     = 3'd3,
        S_ATTACK   = 3'd4,
        S_DRAW     = 3'd5,
        S_DRAW_END = 3'd6
    } state_t;

    state_t            state_q;
    logic [X_W-1:0]    char_x_q, x_pos_q;
    logic [Y_W-1:0]    char_y_q, y_pos_q;
    logic [1:0]        facing_q;
    logic              attacking_q, frame_q, vga_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [AW-1:0]     atk_cnt_q;
    logic              init_done_q, idle_done_q, attack_done_q;
    logic              move_done_q, draw_done_q;

    // Clamped move targets use one extra bit so neither end can wrap.
    logic [X_W:0]   x_inc, x_dec;
    logic [Y_W:0]   y_inc, y_dec;
    logic [X_W-1:0] left_x, right_x;
    logic [Y_W-1:0] up_y, down_y;
    logic [CW-1:0]  col_nxt;
    logic [RW-1:0]  row_nxt;
    logic           last_pix;

    always_comb begin
        x_inc    = {1'b0, char_x_q} + STEP_X;
        x_dec    = {1'b0, char_x_q} - STEP_X;
        y_inc    = {1'b0, char_y_q} + STEP_Y;
        y_dec    = {1'b0, char_y_q} - STEP_Y;
        left_x   = x_dec[X_W] ? '0 : x_dec[X_W-1:0];
        right_x  = (x_inc > X_MAX) ? X_MAX[X_W-1:0] : x_inc[X_W-1:0];
        up_y     = y_dec[Y_W] ? '0 : y_dec[Y_W-1:0];
        down_y   = (y_inc > Y_MAX) ? Y_MAX[Y_W-1:0] : y_inc[Y_W-1:0];
        col_nxt  = col_q + 1'b1;
        row_nxt  = (col_q == '1) ? row_q + 1'b1 : row_q;
        last_pix = (col_q == '1) && (row_q == '1);
    end

    // Sprite sizes are powers of two, so the address is a plain concatenation.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic f, input logic [1:0] d,
                                                   input logic [RW-1:0] r,
                                                   input logic [CW-1:0] c);
        return ADDR_W'({f, d, r, c});
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_READY;
            char_x_q      <= X_INIT;
            char_y_q      <= Y_INIT;
            facing_q      <= 2'd1;
            attacking_q   <= 1'b0;
            frame_q       <= 1'b0;
            vga_write_q   <= 1'b0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            addr_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            atk_cnt_q     <= '0;
            init_done_q   <= 1'b0;
            idle_done_q   <= 1'b0;
            attack_done_q <= 1'b0;
            move_done_q   <= 1'b0;
            draw_done_q   <= 1'b0;
        end else begin
            init_done_q   <= 1'b0;
            idle_done_q   <= 1'b0;
            attack_done_q <= 1'b0;
            move_done_q   <= 1'b0;
            draw_done_q   <= 1'b0;
            case (state_q)
                S_READY: begin
                    if (bus.init) begin
                        state_q     <= S_INIT;
                        char_x_q    <= X_INIT;
                        char_y_q    <= Y_INIT;
                        facing_q    <= 2'd1;
                        attacking_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end else if (bus.idle) begin
                        state_q     <= S_IDLE;
                        idle_done_q <= 1'b1;
                    end else if (bus.attack) begin
                        state_q       <= S_ATTACK;
                        attacking_q   <= 1'b1;
                        atk_cnt_q     <= '0;
                        attack_done_q <= (ATTACK_CYCLES == 1);
                    end else if (bus.up) begin
                        state_q     <= S_MOVE;
                        facing_q    <= 2'd0;
                        move_done_q <= 1'b1;
                        if (!bus.blocked) char_y_q <= up_y;
                    end else if (bus.down) begin
                        state_q     <= S_MOVE;
                        facing_q    <= 2'd1;
                        move_done_q <= 1'b1;
                        if (!bus.blocked) char_y_q <= down_y;
                    end else if (bus.left) begin
                        state_q     <= S_MOVE;
                        facing_q    <= 2'd2;
                        move_done_q <= 1'b1;
                        if (!bus.blocked) char_x_q <= left_x;
                    end else if (bus.right) begin
                        state_q     <= S_MOVE;
                        facing_q    <= 2'd3;
                        move_done_q <= 1'b1;
                        if (!bus.blocked) char_x_q <= right_x;
                    end else if (bus.draw) begin
                        state_q     <= S_DRAW;
                        col_q       <= '0;
                        row_q       <= '0;
                        frame_q     <= attacking_q;
                        vga_write_q <= 1'b1;
                        x_pos_q     <= char_x_q;
                        y_pos_q     <= char_y_q;
                        addr_q      <= pix_addr(attacking_q, facing_q, '0, '0);
                    end
                end
                S_INIT, S_IDLE, S_MOVE, S_DRAW_END: state_q <= S_READY;
                S_ATTACK: begin
                    if (atk_cnt_q == ATK_LAST) begin
                        state_q     <= S_READY;
                        attacking_q <= 1'b0;
                    end else begin
                        atk_cnt_q     <= atk_cnt_q + 1'b1;
                        attack_done_q <= (atk_cnt_q == ATK_PEN);
                    end
                end
                S_DRAW: begin
                    if (last_pix) begin
                        state_q     <= S_DRAW_END;
                        vga_write_q <= 1'b0;
                        draw_done_q <= 1'b1;
                    end else begin
                        col_q   <= col_nxt;
                        row_q   <= row_nxt;
                        x_pos_q <= char_x_q + X_W'(col_nxt);
                        y_pos_q <= char_y_q + Y_W'(row_nxt);
                        addr_q  <= pix_addr(frame_q, facing_q, row_nxt, col_nxt);
                    end
                end
                default: state_q <= S_READY;
            endcase
        end
    end

    assign bus.x_position  = x_pos_q;
    assign bus.y_position  = y_pos_q;
    assign bus.sprite_addr = addr_q;
    assign bus.vga_write   = vga_write_q;
    assign bus.char_x      = char_x_q;
    assign bus.char_y      = char_y_q;
    assign bus.facing      = facing_q;
    assign bus.attacking   = attacking_q;
    assign bus.init_done   = init_done_q;
    assign bus.idle_done   = idle_done_q;
    assign bus.attack_done = attack_done_q;
    assign bus.move_done   = move_done_q;
    assign bus.draw_done   = draw_done_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_char_datapath.sv
// Directed bench for char_datapath: reset, init, moves, clamping, draw scan,
// attack priority and asynchronous reset during a draw.
module tb_char_datapath;
    logic       clock;
    logic       reset;
    logic [2:0] state_dbg;
    int         n_assert;
    int         n_fail;
    int         pulses;

    char_datapath_if #(.X_W(9), .Y_W(8), .ADDR_W(11)) bus ();

    char_datapath dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cmds();
        bus.init = 0; bus.idle = 0; bus.attack = 0; bus.up = 0; bus.down = 0;
        bus.left = 0; bus.right = 0; bus.draw = 0; bus.blocked = 0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_cmds();

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_char_x", bus.char_x, 152);
        check("rst_char_y", bus.char_y, 112);
        check("rst_facing", bus.facing, 1);
        check("rst_xpos", bus.x_position, 0);
        check("rst_ypos", bus.y_position, 0);
        check("rst_addr", bus.sprite_addr, 0);
        check("rst_vga", bus.vga_write, 0);
        check("rst_attacking", bus.attacking, 0);
        check("rst_dones", {bus.init_done, bus.idle_done, bus.attack_done,
                            bus.move_done, bus.draw_done}, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;

        // Init
        @(negedge clock);
        bus.init = 1;
        @(negedge clock);
        check("init_done", bus.init_done, 1);
        check("init_state", state_dbg, 1);
        check("init_char_x", bus.char_x, 152);
        check("init_char_y", bus.char_y, 112);
        check("init_facing", bus.facing, 1);
        bus.init = 0;
        @(negedge clock);
        check("init_done_drop", bus.init_done, 0);
        check("init_ready", state_dbg, 0);

        // Idle
        bus.idle = 1;
        @(negedge clock);
        check("idle_done", bus.idle_done, 1);
        bus.idle = 0;
        @(negedge clock);
        check("idle_done_drop", bus.idle_done, 0);

        // Three right moves held continuously
        bus.right = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("right_move_done", bus.move_done, 1);
            check("right_char_x", bus.char_x, 153 + k);
            if (k == 2) bus.right = 0;
            else begin
                @(negedge clock);
                check("right_ready_gap", bus.move_done, 0);
            end
        end
        @(negedge clock);
        check("right_final_x", bus.char_x, 155);
        check("right_facing", bus.facing, 3);
        check("right_no_extra", bus.move_done, 0);

        // Blocked up: facing changes, position does not
        bus.blocked = 1;
        bus.up = 1;
        @(negedge clock);
        check("blk_move_done", bus.move_done, 1);
        check("blk_char_y", bus.char_y, 112);
        check("blk_facing", bus.facing, 0);
        bus.up = 0;
        bus.right = 1;
        @(negedge clock);
        @(negedge clock);
        check("blk_right_x", bus.char_x, 155);
        check("blk_right_facing", bus.facing, 3);
        bus.right = 0;
        bus.blocked = 0;
        @(negedge clock);

        // Draw at (155,112) facing right
        bus.draw = 1;
        for (int p = 0; p < 256; p++) begin
            @(negedge clock);
            check("draw_vga", bus.vga_write, 1);
            check("draw_x", bus.x_position, 155 + (p % 16));
            check("draw_y", bus.y_position, 112 + (p / 16));
            check("draw_addr", bus.sprite_addr, 768 + p);
            check("draw_done_early", bus.draw_done, 0);
        end
        @(negedge clock);
        check("draw_end_vga", bus.vga_write, 0);
        check("draw_done", bus.draw_done, 1);
        check("draw_hold_x", bus.x_position, 170);
        check("draw_hold_y", bus.y_position, 127);
        check("draw_hold_addr", bus.sprite_addr, 1023);
        bus.draw = 0;
        @(negedge clock);
        check("draw_done_drop", bus.draw_done, 0);
        check("draw_ready", state_dbg, 0);

        // Attack beats up; up is served afterwards
        bus.attack = 1;
        bus.up = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            check("atk_attacking", bus.attacking, 1);
            check("atk_done", bus.attack_done, (c == 8) ? 1 : 0);
            check("atk_char_y", bus.char_y, 112);
            check("atk_no_move", bus.move_done, 0);
            if (c == 8) bus.attack = 0;
        end
        @(negedge clock);
        check("atk_off", bus.attacking, 0);
        check("atk_done_drop", bus.attack_done, 0);
        check("atk_ready", state_dbg, 0);
        @(negedge clock);
        check("atk_up_move", bus.move_done, 1);
        check("atk_up_y", bus.char_y, 111);
        check("atk_up_facing", bus.facing, 0);
        bus.up = 0;
        @(negedge clock);

        // Clamp at left edge: 160 moves requested from x=155
        pulses = 0;
        bus.left = 1;
        repeat (320) begin
            @(negedge clock);
            if (bus.move_done) pulses++;
        end
        bus.left = 0;
        @(negedge clock);
        check("clamp_left_x", bus.char_x, 0);
        check("clamp_left_pulses", pulses, 160);

        // Clamp at right edge: 314 moves requested from x=0
        pulses = 0;
        bus.right = 1;
        repeat (628) begin
            @(negedge clock);
            if (bus.move_done) pulses++;
        end
        bus.right = 0;
        @(negedge clock);
        check("clamp_right_x", bus.char_x, 304);
        check("clamp_right_pulses", pulses, 314);

        // Clamp at bottom edge: 120 moves requested from y=111
        pulses = 0;
        bus.down = 1;
        repeat (240) begin
            @(negedge clock);
            if (bus.move_done) pulses++;
        end
        bus.down = 0;
        @(negedge clock);
        check("clamp_down_y", bus.char_y, 224);
        check("clamp_down_pulses", pulses, 120);
        check("clamp_down_facing", bus.facing, 1);

        // Asynchronous reset in the middle of a draw at (304,224) facing down
        bus.draw = 1;
        repeat (100) @(negedge clock);
        check("mid_vga", bus.vga_write, 1);
        check("mid_x", bus.x_position, 307);
        check("mid_y", bus.y_position, 230);
        check("mid_addr", bus.sprite_addr, 355);
        #2 reset = 1'b0;
        #1;
        check("arst_vga", bus.vga_write, 0);
        check("arst_xpos", bus.x_position, 0);
        check("arst_addr", bus.sprite_addr, 0);
        check("arst_char_x", bus.char_x, 152);
        check("arst_char_y", bus.char_y, 112);
        check("arst_state", state_dbg, 0);
        check("arst_draw_done", bus.draw_done, 0);
        @(negedge clock);
        bus.draw = 0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_draw_done", bus.draw_done, 0);
            check("post_rst_state", state_dbg, 0);
            check("post_rst_vga", bus.vga_write, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
